// File: rtl/i2c_wr_scheduler.sv
// ---------------------------------------------------------------------------
// i2c_wr_scheduler
//
// Shares one single-block-write I2C actuator among NUM_REQ requesters.
// A round-robin arbiter picks a pending requester while the actuator is idle.
// The scheduler then latches that requester's 7-bit target address and data
// byte. It issues the write command and waits for the actuator to finish. It
// retries after actuator errors, up to MAX_RETRY times. Every attempt is
// bounded by a TIMEOUT-cycle watchdog. Each request ends with a one-cycle
// done pulse, plus an error pulse on failure.
//
// Ports
//   clk          : clock, all logic on the rising edge
//   rst_n        : synchronous active-low reset
//   i_req        : level request per requester, held until its done pulse
//   i_taaddr     : packed 7-bit target addresses, requester k at [7k+6:7k]
//   i_wdata      : packed write bytes, requester k at [8k+7:8k]
//   o_gnt        : one-hot owner, high from ISSUE through RESP
//   o_done       : one-cycle completion pulse to the owner
//   o_err        : one-cycle failure pulse, coincident with o_done
//   o_busy       : high whenever the scheduler is not idle
//   o_apb_dv     : actuator command valid
//   o_write      : actuator write select, only high with o_apb_dv
//   o_taaddr6_0  : latched target address
//   o_wdata      : latched write byte
//   i_act_rdy    : actuator ready/busy-bar (1 = idle)
//   i_i2c_err    : actuator error indication
// ---------------------------------------------------------------------------
module i2c_wr_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 1023,
  parameter int MAX_RETRY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [7*NUM_REQ-1:0] i_taaddr,
  input  logic [8*NUM_REQ-1:0] i_wdata,
  output logic [NUM_REQ-1:0]   o_gnt,
  output logic [NUM_REQ-1:0]   o_done,
  output logic [NUM_REQ-1:0]   o_err,
  output logic                 o_busy,
  output logic                 o_apb_dv,
  output logic                 o_write,
  output logic [6:0]           o_taaddr6_0,
  output logic [7:0]           o_wdata,
  input  logic                 i_act_rdy,
  input  logic                 i_i2c_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  // A zero-retry build still needs a 1-bit counter to keep the logic legal.
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [TMR_W-1:0]   timer_q;
  logic [RTY_W-1:0]   retry_q;
  logic               err_seen_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic [NUM_REQ-1:0] err_q;
  logic               busy_q;
  logic               apb_dv_q;
  logic               write_q;
  logic [6:0]         taaddr_q;
  logic [7:0]         wdata_q;

  // Unpack the per-requester operand buses.
  logic [6:0] addr_arr [NUM_REQ];
  logic [7:0] data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = i_taaddr[7*gi +: 7];
    assign data_arr[gi] = i_wdata[8*gi +: 8];
  end

  // Round-robin pick: scan from ptr+1 upward with wrap.
  // The last owner (ptr) is therefore checked last.
  logic             win_vld_d;
  logic [IDX_W-1:0] win_idx_d;
  logic [IDX_W-1:0] cand_d;

  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    cand_d    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_d = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!win_vld_d && i_req[cand_d]) begin
        win_vld_d = 1'b1;
        win_idx_d = cand_d;
      end
    end
  end

  // An error on the sample that ends the attempt still counts for that attempt.
  logic err_now;
  assign err_now = err_seen_q | i_i2c_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= IDX_W'(NUM_REQ - 1);
      idx_q      <= '0;
      timer_q    <= '0;
      retry_q    <= '0;
      err_seen_q <= 1'b0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      apb_dv_q   <= 1'b0;
      write_q    <= 1'b0;
      taaddr_q   <= '0;
      wdata_q    <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (i_act_rdy && win_vld_d) begin
            state_q          <= S_ISSUE;
            idx_q            <= win_idx_d;
            gnt_q            <= '0;
            gnt_q[win_idx_d] <= 1'b1;
            taaddr_q         <= addr_arr[win_idx_d];
            wdata_q          <= data_arr[win_idx_d];
            retry_q          <= '0;
            err_seen_q       <= 1'b0;
            timer_q          <= '0;
            busy_q           <= 1'b1;
            apb_dv_q         <= 1'b1;
            write_q          <= 1'b1;
          end
        end

        S_ISSUE: begin
          if (timer_q == TMR_LIMIT) begin
            // The actuator never took the command: fail without retry.
            state_q       <= S_RESP;
            apb_dv_q      <= 1'b0;
            write_q       <= 1'b0;
            done_q[idx_q] <= 1'b1;
            err_q[idx_q]  <= 1'b1;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
            if (!i_act_rdy) begin
              state_q  <= S_WAIT;
              apb_dv_q <= 1'b0;
              write_q  <= 1'b0;
            end
          end
        end

        S_WAIT: begin
          if (timer_q == TMR_LIMIT) begin
            state_q       <= S_RESP;
            done_q[idx_q] <= 1'b1;
            err_q[idx_q]  <= 1'b1;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
            if (i_i2c_err) begin
              err_seen_q <= 1'b1;
            end
            if (i_act_rdy) begin
              if (err_now && (retry_q < RTY_LIMIT)) begin
                // Re-issue the same latched command with a fresh timer.
                state_q    <= S_ISSUE;
                retry_q    <= retry_q + RTY_W'(1);
                err_seen_q <= 1'b0;
                timer_q    <= '0;
                apb_dv_q   <= 1'b1;
                write_q    <= 1'b1;
              end else begin
                state_q       <= S_RESP;
                done_q[idx_q] <= 1'b1;
                err_q[idx_q]  <= err_now;
              end
            end
          end
        end

        S_RESP: begin
          state_q <= S_IDLE;
          ptr_q   <= idx_q;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_gnt       = gnt_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_busy      = busy_q;
  assign o_apb_dv    = apb_dv_q;
  assign o_write     = write_q;
  assign o_taaddr6_0 = taaddr_q;
  assign o_wdata     = wdata_q;

endmodule

// File: doc/i2c_wr_scheduler.md
# i2c_wr_scheduler

Round-robin scheduler that shares the single-block-write I2C actuator among `NUM_REQ` requesters. It arbitrates pending write requests and latches the winner's 7-bit target address and 8-bit data. It then drives the actuator's `apb_dv`/`write` command pins and tracks the actuator's ready/busy-bar flag. Per requester it returns a done pulse plus an error flag after bounded retry and timeout handling. It sits between the register/APB front end and the actuator's command inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 1023: max cycles per attempt, counted from ISSUE entry until the actuator returns ready.
- `MAX_RETRY`, 2: re-issues allowed after an actuator error; 0 disables retry.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `i_req`  in  NUM_REQ  level request per requester; held until its `o_done` pulse.
- `i_taaddr`  in  7*NUM_REQ  target addresses, requester k at bits [7k+6:7k].
- `i_wdata`  in  8*NUM_REQ  write bytes, requester k at bits [8k+7:8k].
- `o_gnt`  out  NUM_REQ  one-hot, high from ISSUE through RESP for the owner.
- `o_done`  out  NUM_REQ  1-cycle pulse in RESP for the owner.
- `o_err`  out  NUM_REQ  1-cycle pulse, coincident with `o_done`, on failure.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_apb_dv`  out  1  actuator command valid, active-high.
- `o_write`  out  1  actuator write select, high only with `o_apb_dv`.
- `o_taaddr6_0`  out  7  latched target address.
- `o_wdata`  out  8  latched write byte.
- `i_act_rdy`  in  1  actuator ready/busy-bar: 1 = idle, 0 = transfer in progress.
- `i_i2c_err`  in  1  actuator error indication.

## Operation
- States: IDLE, ISSUE, WAIT_DONE, RESP.
- **IDLE**
  - If `i_act_rdy`=1 and any `i_req` is set, select the winner by round-robin.
  - Search starts at `ptr+1` and wraps modulo NUM_REQ.
  - Latch the winner's index, address and data, clear the retry count, and go to ISSUE.
  - If `i_act_rdy`=0, no grant is made.
- **ISSUE**
  - Drive `o_apb_dv`=1 and `o_write`=1.
  - When `i_act_rdy`=0 is sampled, the command is accepted: go to WAIT_DONE and drop `o_apb_dv`.
- **WAIT_DONE**
  - A sticky `err_seen` bit is set by any `i_i2c_err`=1 sample during this attempt.
  - When `i_act_rdy` returns to 1:
    - If `err_seen`=1 and retry count < MAX_RETRY: increment the retry count, clear `err_seen`, re-enter ISSUE.
    - Otherwise go to RESP.
- **Timeout**
  - A timer clears on every ISSUE entry and increments in ISSUE and WAIT_DONE.
  - Timer == TIMEOUT in either state goes to RESP with failure. A timeout is never retried.
- **RESP**
  - Pulse `o_done[idx]`.
  - Pulse `o_err[idx]` if the attempt timed out, or `err_seen`=1 with retries exhausted.
  - Set `ptr`=idx and return to IDLE.
- **Width rules**
  - Timer is $clog2(TIMEOUT+1) bits, retry count is $clog2(MAX_RETRY+1) bits; neither wraps.
  - `ptr` is $clog2(NUM_REQ) bits.
- **Boundary conditions**
  - A request that is withdrawn early is ignored: the latched command completes and still pulses done to that index.
  - Requests arriving during a busy period wait until IDLE.
  - The owner's request, still high in its RESP cycle, has lowest priority at the next arbitration.

## Timing
- **Reset** (`rst_n`=0 at a rising edge):
  - State IDLE, `ptr`=NUM_REQ-1 so requester 0 has first priority.
  - All outputs 0, including `o_taaddr6_0` and `o_wdata`; timer, retry count and `err_seen` cleared.
- **Reset mid-transfer**
  - The actuator is not aborted. No done/err pulse is ever produced for the aborted owner.
  - The scheduler grants nothing until `i_act_rdy`=1.
- **Grant latency**
  - `i_req` sampled high in IDLE at edge N (with `i_act_rdy`=1) gives `o_gnt`, `o_busy`, `o_apb_dv` and valid address/data in cycle N+1.
- **Command hold**
  - `o_apb_dv` stays high until the edge that samples `i_act_rdy`=0, then is low the next cycle.
  - Address and data stay stable from ISSUE through RESP.
- **Completion**
  - The `i_act_rdy` 0→1 sample leads to RESP in the next cycle, with the done pulse lasting 1 cycle.
  - Back-to-back minimum spacing between consecutive `o_apb_dv` rises: RESP, IDLE, ISSUE, i.e. 2 cycles after RESP.
- **Retry**
  - Re-issue `o_apb_dv` in the cycle after the `i_act_rdy` 0→1 sample.

## Test plan
- Single request, addr 0x50, data 0xA5, actuator busy for 20 cycles, no error -> `o_apb_dv` held 1 cycle past acceptance; `o_taaddr6_0`=0x50 and `o_wdata`=0xA5; `o_done[0]` pulse, `o_err`=0.
- All 4 requests held continuously -> grant order 0,1,2,3,0; each `o_gnt` one-hot; no overlapping transactions.
- `i_i2c_err` pulsed in every attempt with MAX_RETRY=2 -> exactly 3 `o_apb_dv` assertions, then `o_done[k]` and `o_err[k]` pulse together.
- Error in the first attempt only -> exactly 2 assertions, `o_done` pulse with `o_err`=0.
- Actuator never asserts busy (`i_act_rdy` stuck 1), TIMEOUT=1023 -> RESP reached 1024 cycles after ISSUE entry, `o_err` pulse, no retry.
- `rst_n` low for 1 cycle during WAIT_DONE while `i_act_rdy`=0 -> outputs 0 next cycle; no grant until `i_act_rdy`=1; requester 0 then wins first.
